// File: rtl/cache_fill_arbiter.sv
// Block-refill controller: arbitrates cache misses and write-through stores onto one
// pipelined memory, issues one read per cycle per block word and steers returning words.
module cache_fill_arbiter #(
    parameter int NUM_REQ  = 2,
    parameter int WORDS    = 8,
    parameter int MEM_LAT  = 4,
    parameter int ARB_MODE = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         miss,
    input  logic [16*NUM_REQ-1:0]      miss_addr,
    input  logic                       wr_req,
    input  logic [15:0]                wr_addr,
    input  logic [15:0]                wr_data,
    output logic                       wr_ack,
    output logic                       mem_en,
    output logic                       mem_wr,
    output logic [15:0]                mem_addr,
    output logic [15:0]                mem_data_in,
    input  logic [15:0]                mem_data,
    input  logic                       mem_data_valid,
    output logic [NUM_REQ-1:0]         grant,
    output logic                       fill_we,
    output logic [$clog2(WORDS)-1:0]   fill_word,
    output logic [15:0]                fill_data,
    output logic                       fill_tag_we,
    output logic                       busy
);

    localparam int CW = $clog2(WORDS);
    localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [15:0] BLK_MASK = 16'(2 * WORDS - 1);
    localparam logic [CW-1:0] LAST_WORD = CW'(WORDS - 1);

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_DRAIN} state_t;

    state_t        state_q, state_d;
    logic [OW-1:0] owner_q, owner_d;
    logic [15:0]   base_q, base_d;
    logic [CW-1:0] issue_cnt_q, issue_cnt_d;
    logic [CW-1:0] rcv_cnt_q, rcv_cnt_d;
    logic [OW-1:0] rr_ptr_q, rr_ptr_d;

    logic [OW-1:0] winner;
    logic [OW-1:0] cand;
    logic          found;

    // The controller counts returned words rather than timing them, so MEM_LAT never
    // enters the logic; a latency below one cycle is not a meaningful memory.
    if (MEM_LAT < 1) begin : g_mem_lat_unsupported
    end

    // Winner search: from index 0 in fixed mode, from rr_ptr (wrapping) in round-robin.
    always_comb begin
        winner = '0;
        cand   = '0;
        found  = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (ARB_MODE == 1) begin
                cand = OW'((int'(rr_ptr_q) + k) % NUM_REQ);
            end else begin
                cand = OW'(k);
            end
            if (!found && miss[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        base_d      = base_q;
        issue_cnt_d = issue_cnt_q;
        rcv_cnt_d   = rcv_cnt_q;
        rr_ptr_d    = rr_ptr_q;
        wr_ack      = 1'b0;
        mem_en      = 1'b0;
        mem_wr      = 1'b0;
        mem_addr    = '0;
        mem_data_in = '0;
        fill_we     = 1'b0;
        fill_word   = '0;
        fill_data   = '0;
        fill_tag_we = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (wr_req) begin
                    mem_en      = 1'b1;
                    mem_wr      = 1'b1;
                    mem_addr    = wr_addr;
                    mem_data_in = wr_data;
                    wr_ack      = 1'b1;
                end else if (found) begin
                    owner_d     = winner;
                    base_d      = miss_addr[16*int'(winner) +: 16] & ~BLK_MASK;
                    issue_cnt_d = '0;
                    rcv_cnt_d   = '0;
                    rr_ptr_d    = OW'((int'(winner) + 1) % NUM_REQ);
                    state_d     = S_FILL;
                end
            end
            S_FILL: begin
                mem_en      = 1'b1;
                mem_addr    = base_q | {{(15 - CW){1'b0}}, issue_cnt_q, 1'b0};
                issue_cnt_d = issue_cnt_q + CW'(1);
                if (issue_cnt_q == LAST_WORD) begin
                    state_d = S_DRAIN;
                end
            end
            default: ;
        endcase

        // Returning words are accepted in FILL as well as DRAIN (latency may be short).
        if (state_q != S_IDLE && mem_data_valid) begin
            fill_we   = 1'b1;
            fill_word = rcv_cnt_q;
            fill_data = mem_data;
            rcv_cnt_d = rcv_cnt_q + CW'(1);
            if (rcv_cnt_q == LAST_WORD) begin
                fill_tag_we = 1'b1;
                state_d     = S_IDLE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            owner_q     <= '0;
            base_q      <= '0;
            issue_cnt_q <= '0;
            rcv_cnt_q   <= '0;
            rr_ptr_q    <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            base_q      <= base_d;
            issue_cnt_q <= issue_cnt_d;
            rcv_cnt_q   <= rcv_cnt_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign busy = (state_q != S_IDLE);

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_grant
        assign grant[gi] = busy && (owner_q == OW'(gi));
    end

endmodule

// File: tb/tb_cache_fill_arbiter.sv
// Directed bench for cache_fill_arbiter: three instances (fixed priority, round-robin,
// short block with long latency), each fed by a small pipelined memory model.
module tb_cache_fill_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Instance A: defaults, fixed priority
    logic [1:0]  a_miss;
    logic [31:0] a_maddr;
    logic        a_wr_req;
    logic [15:0] a_wr_addr, a_wr_data;
    logic        a_wr_ack, a_mem_en, a_mem_wr;
    logic [15:0] a_mem_addr, a_mem_din, a_mem_data;
    logic        a_mem_valid, a_stray;
    logic [1:0]  a_grant;
    logic        a_fill_we, a_tag_we, a_busy;
    logic [2:0]  a_fill_word;
    logic [15:0] a_fill_data;

    // Instance B: round-robin
    logic [1:0]  b_miss;
    logic [31:0] b_maddr;
    logic        b_wr_ack, b_mem_en, b_mem_wr;
    logic [15:0] b_mem_addr, b_mem_din, b_mem_data;
    logic        b_mem_valid;
    logic [1:0]  b_grant;
    logic        b_fill_we, b_tag_we, b_busy;
    logic [2:0]  b_fill_word;
    logic [15:0] b_fill_data;

    // Instance C: WORDS=4, MEM_LAT=6
    logic [1:0]  c_miss;
    logic [31:0] c_maddr;
    logic        c_wr_ack, c_mem_en, c_mem_wr;
    logic [15:0] c_mem_addr, c_mem_din, c_mem_data;
    logic        c_mem_valid;
    logic [1:0]  c_grant;
    logic        c_fill_we, c_tag_we, c_busy;
    logic [1:0]  c_fill_word;
    logic [15:0] c_fill_data;

    cache_fill_arbiter #(.NUM_REQ(2), .WORDS(8), .MEM_LAT(4), .ARB_MODE(0)) u_a (
        .clk(clk), .rst(rst), .miss(a_miss), .miss_addr(a_maddr),
        .wr_req(a_wr_req), .wr_addr(a_wr_addr), .wr_data(a_wr_data), .wr_ack(a_wr_ack),
        .mem_en(a_mem_en), .mem_wr(a_mem_wr), .mem_addr(a_mem_addr), .mem_data_in(a_mem_din),
        .mem_data(a_mem_data), .mem_data_valid(a_mem_valid), .grant(a_grant),
        .fill_we(a_fill_we), .fill_word(a_fill_word), .fill_data(a_fill_data),
        .fill_tag_we(a_tag_we), .busy(a_busy)
    );

    cache_fill_arbiter #(.NUM_REQ(2), .WORDS(8), .MEM_LAT(4), .ARB_MODE(1)) u_b (
        .clk(clk), .rst(rst), .miss(b_miss), .miss_addr(b_maddr),
        .wr_req(1'b0), .wr_addr(16'h0000), .wr_data(16'h0000), .wr_ack(b_wr_ack),
        .mem_en(b_mem_en), .mem_wr(b_mem_wr), .mem_addr(b_mem_addr), .mem_data_in(b_mem_din),
        .mem_data(b_mem_data), .mem_data_valid(b_mem_valid), .grant(b_grant),
        .fill_we(b_fill_we), .fill_word(b_fill_word), .fill_data(b_fill_data),
        .fill_tag_we(b_tag_we), .busy(b_busy)
    );

    cache_fill_arbiter #(.NUM_REQ(2), .WORDS(4), .MEM_LAT(6), .ARB_MODE(0)) u_c (
        .clk(clk), .rst(rst), .miss(c_miss), .miss_addr(c_maddr),
        .wr_req(1'b0), .wr_addr(16'h0000), .wr_data(16'h0000), .wr_ack(c_wr_ack),
        .mem_en(c_mem_en), .mem_wr(c_mem_wr), .mem_addr(c_mem_addr), .mem_data_in(c_mem_din),
        .mem_data(c_mem_data), .mem_data_valid(c_mem_valid), .grant(c_grant),
        .fill_we(c_fill_we), .fill_word(c_fill_word), .fill_data(c_fill_data),
        .fill_tag_we(c_tag_we), .busy(c_busy)
    );

    // Memory models: a read issued in cycle n returns addr^BEEF in cycle n+MEM_LAT.
    // They ignore rst so that in-flight reads really do arrive after a reset.
    logic [15:0] a_pa [4];
    logic [3:0]  a_pv = '0;
    logic [15:0] b_pa [4];
    logic [3:0]  b_pv = '0;
    logic [15:0] c_pa [6];
    logic [5:0]  c_pv = '0;

    always @(posedge clk) begin
        a_pv <= {a_pv[2:0], a_mem_en & ~a_mem_wr};
        b_pv <= {b_pv[2:0], b_mem_en & ~b_mem_wr};
        c_pv <= {c_pv[4:0], c_mem_en & ~c_mem_wr};
        a_pa[0] <= a_mem_addr;
        b_pa[0] <= b_mem_addr;
        c_pa[0] <= c_mem_addr;
        for (int i = 1; i < 4; i++) begin
            a_pa[i] <= a_pa[i-1];
            b_pa[i] <= b_pa[i-1];
        end
        for (int i = 1; i < 6; i++) c_pa[i] <= c_pa[i-1];
    end

    assign a_mem_valid = a_pv[3] | a_stray;
    assign a_mem_data  = a_pa[3] ^ 16'hBEEF;
    assign b_mem_valid = b_pv[3];
    assign b_mem_data  = b_pa[3] ^ 16'hBEEF;
    assign c_mem_valid = c_pv[5];
    assign c_mem_data  = c_pa[5] ^ 16'hBEEF;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Runs one default-size fill on instance A. Entered in the IDLE cycle where the miss is
    // already driven; returns in the first IDLE cycle afterwards with next_miss applied.
    // wr_at (1..12) raises a write request inside the fill.
    task automatic fill_a(input logic [1:0] g, input logic [15:0] base,
                          input logic [1:0] next_miss, input int wr_at);
        logic [15:0] ea;
        #1;
        chk("a_start_busy", 32'(a_busy), 32'(0));
        chk("a_start_grant", 32'(a_grant), 32'(0));
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk); #1;
            if (c == wr_at) begin
                a_wr_req  = 1'b1;
                a_wr_addr = 16'h5002;
                a_wr_data = 16'h1234;
            end
            #1;
            chk("a_grant", 32'(a_grant), 32'(g));
            chk("a_busy", 32'(a_busy), 32'(1));
            chk("a_mem_en", 32'(a_mem_en), 32'(c <= 8));
            chk("a_mem_wr", 32'(a_mem_wr), 32'(0));
            chk("a_wr_ack", 32'(a_wr_ack), 32'(0));
            if (c <= 8) begin
                ea = base + 16'(2 * (c - 1));
                chk("a_mem_addr", 32'(a_mem_addr), 32'(ea));
            end
            chk("a_fill_we", 32'(a_fill_we), 32'(c >= 5));
            if (c >= 5) begin
                ea = base + 16'(2 * (c - 5));
                chk("a_fill_word", 32'(a_fill_word), 32'(c - 5));
                chk("a_fill_data", 32'(a_fill_data), 32'(ea ^ 16'hBEEF));
            end
            chk("a_tag_we", 32'(a_tag_we), 32'(c == 12));
        end
        @(posedge clk); #1;
        a_miss = next_miss;
        #1;
        chk("a_end_busy", 32'(a_busy), 32'(0));
        chk("a_end_grant", 32'(a_grant), 32'(0));
        chk("a_end_fill_we", 32'(a_fill_we), 32'(0));
    endtask

    initial begin
        int n;
        logic [15:0] ea;
        a_miss = '0; a_maddr = '0; a_wr_req = 1'b0; a_wr_addr = '0; a_wr_data = '0; a_stray = 1'b0;
        b_miss = '0; b_maddr = '0;
        c_miss = '0; c_maddr = '0;

        // Reset state
        @(posedge clk); #1;
        chk("rst_busy", 32'(a_busy), 32'(0));
        chk("rst_mem_en", 32'(a_mem_en), 32'(0));
        chk("rst_grant", 32'(a_grant), 32'(0));
        chk("rst_fill_we", 32'(a_fill_we), 32'(0));
        chk("rst_tag_we", 32'(a_tag_we), 32'(0));
        chk("rst_wr_ack", 32'(a_wr_ack), 32'(0));
        chk("rst_mem_addr", 32'(a_mem_addr), 32'(0));
        chk("rst_b_busy", 32'(b_busy), 32'(0));
        chk("rst_c_busy", 32'(c_busy), 32'(0));
        @(posedge clk); #1;
        rst = 1'b0;

        // Single I-cache fill at 0x1236
        @(posedge clk); #1;
        a_maddr[31:16] = 16'h1236;
        a_miss = 2'b10;
        fill_a(2'b10, 16'h1230, 2'b00, 0);

        // Simultaneous misses: D first, I in the first IDLE cycle after D drops
        @(posedge clk); #1;
        a_maddr = {16'h2F1A, 16'h0456};
        a_miss = 2'b11;
        fill_a(2'b01, 16'h0450, 2'b10, 0);
        fill_a(2'b10, 16'h2F10, 2'b00, 0);

        // Write wins over a simultaneous miss; fill starts the next cycle
        @(posedge clk); #1;
        a_wr_req = 1'b1; a_wr_addr = 16'h4000; a_wr_data = 16'hCAFE;
        a_maddr[15:0] = 16'h0813; a_miss = 2'b01;
        #1;
        chk("wp_wr_ack", 32'(a_wr_ack), 32'(1));
        chk("wp_mem_en", 32'(a_mem_en), 32'(1));
        chk("wp_mem_wr", 32'(a_mem_wr), 32'(1));
        chk("wp_mem_addr", 32'(a_mem_addr), 32'(16'h4000));
        chk("wp_mem_din", 32'(a_mem_din), 32'(16'hCAFE));
        chk("wp_busy", 32'(a_busy), 32'(0));
        @(posedge clk); #1;
        a_wr_req = 1'b0;
        fill_a(2'b01, 16'h0810, 2'b00, 0);

        // Write arriving mid-fill is acked only once IDLE again
        @(posedge clk); #1;
        a_maddr[15:0] = 16'h0A02; a_miss = 2'b01;
        fill_a(2'b01, 16'h0A00, 2'b00, 3);
        chk("wf_wr_ack", 32'(a_wr_ack), 32'(1));
        chk("wf_mem_wr", 32'(a_mem_wr), 32'(1));
        chk("wf_mem_addr", 32'(a_mem_addr), 32'(16'h5002));
        chk("wf_mem_din", 32'(a_mem_din), 32'(16'h1234));
        @(posedge clk); #1;
        a_wr_req = 1'b0;
        #1;
        chk("wf_wr_ack_drop", 32'(a_wr_ack), 32'(0));

        // Reset after three fill_we pulses
        @(posedge clk); #1;
        a_maddr[15:0] = 16'h7778; a_miss = 2'b01;
        n = 0;
        for (int c = 1; c <= 7; c++) begin
            @(posedge clk); #1; #1;
            if (a_fill_we) n++;
        end
        chk("mr_pre_fills", 32'(n), 32'(3));
        @(posedge clk); #1;
        rst = 1'b1; a_miss = 2'b00;
        #1;
        chk("mr_busy", 32'(a_busy), 32'(0));
        chk("mr_mem_en", 32'(a_mem_en), 32'(0));
        chk("mr_mem_wr", 32'(a_mem_wr), 32'(0));
        chk("mr_wr_ack", 32'(a_wr_ack), 32'(0));
        chk("mr_grant", 32'(a_grant), 32'(0));
        chk("mr_fill_we", 32'(a_fill_we), 32'(0));
        chk("mr_tag_we", 32'(a_tag_we), 32'(0));
        chk("mr_mem_addr", 32'(a_mem_addr), 32'(0));
        chk("mr_mem_din", 32'(a_mem_din), 32'(0));
        chk("mr_fill_word", 32'(a_fill_word), 32'(0));
        chk("mr_fill_data", 32'(a_fill_data), 32'(0));
        @(posedge clk); #1;
        rst = 1'b0; a_stray = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk("mr_stray_fill_we", 32'(a_fill_we), 32'(0));
            chk("mr_stray_busy", 32'(a_busy), 32'(0));
            @(posedge clk); #1;
        end
        a_stray = 1'b0;
        a_miss = 2'b01;
        fill_a(2'b01, 16'h7770, 2'b00, 0);

        // Round-robin with both misses held: 01, 10, 01, 10
        @(posedge clk); #1;
        b_maddr = {16'h3000, 16'h1000};
        b_miss = 2'b11;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1; #1;
            if (c == 1 || c == 27) chk("rr_grant_d", 32'(b_grant), 32'(2'b01));
            if (c == 14 || c == 40) chk("rr_grant_i", 32'(b_grant), 32'(2'b10));
            if (c == 13 || c == 26 || c == 39) chk("rr_idle_gap", 32'(b_busy), 32'(0));
        end
        b_miss = 2'b00;

        // WORDS=4, MEM_LAT=6: all issues precede the first return; 11-cycle fill
        @(posedge clk); #1;
        c_maddr[15:0] = 16'h0105; c_miss = 2'b01;
        #1;
        chk("s_start_busy", 32'(c_busy), 32'(0));
        for (int c = 1; c <= 11; c++) begin
            @(posedge clk); #1;
            if (c == 11) c_miss = 2'b00;
            #1;
            chk("s_mem_en", 32'(c_mem_en), 32'(c <= 4));
            if (c <= 4) begin
                ea = 16'h0100 + 16'(2 * (c - 1));
                chk("s_mem_addr", 32'(c_mem_addr), 32'(ea));
            end
            chk("s_busy", 32'(c_busy), 32'(c <= 10));
            chk("s_grant", 32'(c_grant), (c <= 10) ? 32'(2'b01) : 32'(0));
            chk("s_fill_we", 32'(c_fill_we), 32'(c >= 7 && c <= 10));
            if (c >= 7 && c <= 10) begin
                ea = 16'h0100 + 16'(2 * (c - 7));
                chk("s_fill_word", 32'(c_fill_word), 32'(c - 7));
                chk("s_fill_data", 32'(c_fill_data), 32'(ea ^ 16'hBEEF));
            end
            chk("s_tag_we", 32'(c_tag_we), 32'(c == 10));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cache_fill_arbiter.md
# cache_fill_arbiter

Parametrised cache-fill controller that serves block refills for up to NUM_REQ caches and single-word write-through stores, all sharing one pipelined main memory. It sits between the I/D caches and main memory. It arbitrates among pending misses, issues one read per cycle for every word of the missing block, and steers returning words into the winning cache's data array. It then writes that cache's tag.

## Interface
- NUM_REQ, 2: number of miss requesters (1..4); index 0 = D-cache, 1 = I-cache.
- WORDS, 8: 16-bit words per cache block; power of two, 2..16.
- MEM_LAT, 4: cycles from read issue (mem_en=1, mem_wr=0) to mem_data_valid.
- ARB_MODE, 0: 0 = fixed priority (lowest index wins); 1 = round-robin.
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- miss  in  NUM_REQ  per-requester miss; held until that requester's tag is written.
- miss_addr  in  16*NUM_REQ  byte address of each miss; requester i occupies bits [16i+15:16i].
- wr_req  in  1  write-through request; held until wr_ack.
- wr_addr  in  16  write byte address.
- wr_data  in  16  write data.
- wr_ack  out  1  one-cycle pulse in the cycle the write is issued to memory.
- mem_en  out  1  memory enable.
- mem_wr  out  1  memory write strobe.
- mem_addr  out  16  memory byte address.
- mem_data_in  out  16  memory write data.
- mem_data  in  16  memory read data.
- mem_data_valid  in  1  mem_data is valid this cycle.
- grant  out  NUM_REQ  one-hot owner of the current fill; 0 when idle.
- fill_we  out  1  write fill_data into the granted cache at word fill_word.
- fill_word  out  log2(WORDS)  word index within the block.
- fill_data  out  16  equals mem_data.
- fill_tag_we  out  1  write the tag of the granted cache.
- busy  out  1  state ≠ IDLE.

## Operation
- States: IDLE, FILL, DRAIN.
- Arbitration happens in IDLE only.
  - wr_req has priority over any miss. If wr_req=1: mem_en=1, mem_wr=1, mem_addr=wr_addr, mem_data_in=wr_data, wr_ack=1 (combinational in that cycle); state stays IDLE.
  - Otherwise, if any miss is set: latch the winner into owner, latch base = miss_addr[owner] & ~(2*WORDS-1), clear both counters, and go to FILL.
- Fixed priority: the lowest set index wins.
- Round-robin: the search starts at rr_ptr, wrapping modulo NUM_REQ. On each fill grant, rr_ptr ← owner+1 mod NUM_REQ.
- FILL:
  - Each cycle: mem_en=1, mem_wr=0, mem_addr = base + 2*issue_cnt; then issue_cnt increments.
  - After the word with issue_cnt = WORDS-1 is issued, go to DRAIN. If WORDS ≤ MEM_LAT this happens with no data yet returned; the data accepted in FILL and DRAIN is identical either way.
- Data acceptance, in FILL or DRAIN only:
  - When mem_data_valid=1: fill_we=1, fill_word=rcv_cnt, fill_data=mem_data; then rcv_cnt increments.
  - When rcv_cnt = WORDS-1 with valid: fill_tag_we=1 in the same cycle, and the next state is IDLE.
- mem_data_valid is ignored in IDLE. No fill_we is produced in IDLE.
- wr_req arriving during FILL/DRAIN waits; wr_ack=0 until return to IDLE.
- New misses arriving during a fill are not granted until IDLE.
- Counters are log2(WORDS) wide. issue_cnt and rcv_cnt are never compared beyond WORDS-1.
- grant = one-hot(owner) in FILL and DRAIN, else 0.
- Reset (async, any state, including mid-fill):
  - state=IDLE; owner, base, issue_cnt, rcv_cnt, rr_ptr = 0.
  - All outputs 0: mem_en, mem_wr, wr_ack, grant, fill_we, fill_tag_we, busy. mem_addr, mem_data_in, fill_word and fill_data are 0 when idle.
  - Memory responses still in flight after reset are ignored because the state is IDLE.

## Timing
- Miss sampled in IDLE at cycle t → FILL from t+1; words are issued at t+1 … t+WORDS.
- Word k valid at t+1+k+MEM_LAT. The last fill_we and fill_tag_we occur at t+WORDS+MEM_LAT; IDLE from t+WORDS+MEM_LAT+1.
- Fill penalty: WORDS+MEM_LAT+1 cycles (13 at defaults).
- The requester drops miss the cycle after fill_tag_we, so the first IDLE cycle does not re-grant it.
- Write-through: issued in the first IDLE cycle with wr_req=1; wr_ack occurs in that same cycle. The requester drops wr_req the next cycle.
- Back-to-back: a second pending miss is granted in the first IDLE cycle after the previous fill. A pending wr_req pre-empts it by one cycle.

## Test plan
- Single fill, defaults: miss[1] with miss_addr=0x1236 at t.
  - Required: mem_addr 0x1230, 0x1232 … 0x123E on t+1..t+8.
  - Required: fill_word 0..7 on t+5..t+12, fill_tag_we at t+12, busy low at t+13.
- Simultaneous misses, ARB_MODE=0: miss=2'b11.
  - Required: grant=01 (D-cache) first.
  - Required: I-cache granted at the first IDLE cycle after D drops miss, 13 cycles later.
- Round-robin, ARB_MODE=1, both misses held continuously.
  - Required: grants alternate 01,10,01; rr_ptr wraps at NUM_REQ.
- Write priority: wr_req and miss[0] asserted together in IDLE.
  - Required: wr_ack with mem_wr=1, mem_addr=wr_addr that cycle; the fill starts the next cycle.
  - wr_req asserted during a fill: ack only after return to IDLE.
- Reset mid-fill: assert rst after 3 fill_we pulses.
  - Required: all outputs 0 immediately; stray mem_data_valid pulses afterwards produce no fill_we.
  - Required: the next miss refills from word 0.
- WORDS=4, MEM_LAT=6: FILL→DRAIN occurs before any valid; total 11 cycles; tag written on the 4th word.
